line_raster_engine: RTL
=======================

// Module: line_raster_engine
// PURPOSE
//  Parametrised Bresenham line rasteriser for the video overlay path; next generation of the
//  per-scanline line drawer. Accepts queued line commands (endpoints + colour) over valid/ready,
//  covers all eight octants, and streams one pixel per cycle (x, y, colour, last) over valid/ready
//  to the frame-buffer writer. Adds a command FIFO, backpressure, abort and optional screen clipping.
// PARAMETERS
//  XW        11    x-coordinate width (bits, unsigned)
//  YW        10    y-coordinate width (bits, unsigned)
//  CW        24    colour word width, passed through unchanged
//  CMD_DEPTH 4     command FIFO depth (power of 2, >=2)
//  CLIP_EN   1     1: suppress pixels with x>=H_MAX or y>=V_MAX; 0: emit all
//  H_MAX     800   horizontal clip limit (exclusive)
//  V_MAX     480   vertical clip limit (exclusive)
// PORTS
//  clk         in   1    system clock; single clock domain
//  reset       in   1    synchronous, active-high reset
//  abort       in   1    sync flush: drop FIFO contents and line in progress
//  cmd_valid   in   1    command present
//  cmd_ready   out  1    FIFO not full
//  cmd_x0,x1   in   XW   start / end x
//  cmd_y0,y1   in   YW   start / end y
//  cmd_color   in   CW   line colour
//  px_valid    out  1    pixel present
//  px_ready    in   1    sink accepts pixel
//  px_x        out  XW   pixel x
//  px_y        out  YW   pixel y
//  px_color    out  CW   colour of owning command
//  px_last     out  1    final pixel of the line (endpoint x1,y1)
//  busy        out  1    engine not IDLE or FIFO non-empty
// BEHAVIOUR
//  - Reset (and abort): FIFO empty, state IDLE, px_valid=0, px_last=0, px_x/px_y/px_color=0,
//    busy=0, cmd_ready=1 from the next cycle. abort with reset: same result. abort wins over cmd push.
//  - FSM IDLE -> SETUP -> RUN -> IDLE. IDLE pops FIFO when non-empty. SETUP (1 cycle):
//    dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+-1, err=dx+dy; signed, width max(XW,YW)+2, no overflow.
//  - RUN: current point held in px_x/px_y. Step only on px_valid&&px_ready (or suppressed pixel):
//    e2=2*err; if e2>=dy {err+=dy; x+=sx}; if e2<=dx {err+=dx; y+=sy}. Both may apply (diagonal).
//  - Pixel count per line = max(|x1-x0|,|y1-y0|)+1, first (x0,y0), last (x1,y1), px_last=1 only there.
//  - x0==x1 && y0==y1: exactly one pixel with px_last=1.
//  - Latency: command pushed into empty FIFO while IDLE -> px_valid high 3 cycles later
//    (push, pop/IDLE, SETUP). Throughput 1 pixel/cycle with px_ready=1.
//  - Back-to-back: handshake of last pixel -> IDLE; next command's first pixel 2 cycles later.
//  - Backpressure: while px_valid && !px_ready, px_* held stable; engine state frozen.
//  - Clipping (CLIP_EN=1): off-screen point is stepped internally with px_valid=0, 1 cycle each;
//    if endpoint is off-screen, line ends silently (no px_last emitted). CLIP_EN=0: never suppressed.
//  - FIFO: push on cmd_valid&&cmd_ready; simultaneous push+pop when full allowed only if pop frees
//    a slot the same cycle is NOT assumed — cmd_ready is a pure !full (registered count).
//  - Coordinates never wrap: stepping stops exactly at endpoint; no arithmetic past x1/y1.
//  - busy falls the cycle after the final pixel handshake when FIFO empty.
// STRUCTURE
//  - line_pkg: typedef point_t {x,y}, line_cmd_t {p0,p1,color}, state_t enum {IDLE,SETUP,RUN},
//    localparam ERR_W = max(XW,YW)+2.
//  - Sub-module line_cmd_fifo: synchronous FIFO of line_cmd_t, CMD_DEPTH, flush input = abort.
//  - Top: FSM + Bresenham datapath, all sequential logic in one clocked process, nonblocking only.
// TESTING
//  - Horizontal (0,5)->(9,5), px_ready=1: 10 pixels x=0..9,y=5, last on x=9, 1/cycle, latency 3.
//  - Steep reverse (4,10)->(2,3): 8 pixels, y 10..3 monotonic, x from 4 to 2, last at (2,3).
//  - Single point (7,7)->(7,7): one pixel (7,7) px_last=1, then busy=0 next cycle.
//  - Random px_ready (50%) on (0,0)->(20,13): sequence identical to ready=1 golden, held stable.
//  - Queue 5 cmds, CMD_DEPTH=4: cmd_ready low after 4, all 5 lines emitted in order, 2-cycle gaps.
//  - Clip (790,0)->(810,0), CLIP_EN=1: 10 pixels x=790..799, no px_last; abort mid-line -> px_valid=0 next cycle, FIFO empty.

Source files
------------

// File: rtl/line_pkg.sv
// Shared types and helpers for the line rasteriser: FSM states, default geometry
// and the signed error-term width rule used by the Bresenham datapath.
package line_pkg;

  localparam int DEF_XW = 11;
  localparam int DEF_YW = 10;
  localparam int DEF_CW = 24;

  // Error term must hold 2*dx and -2*dy without overflow.
  function automatic int err_width(input int xw, input int yw);
    return ((xw > yw) ? xw : yw) + 2;
  endfunction

  localparam int ERR_W = err_width(DEF_XW, DEF_YW);

  typedef struct packed {
    logic [DEF_XW-1:0] x;
    logic [DEF_YW-1:0] y;
  } point_t;

  typedef struct packed {
    point_t            p0;
    point_t            p1;
    logic [DEF_CW-1:0] color;
  } line_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/line_cmd_fifo.sv
// Synchronous command FIFO with a registered occupancy count; flush empties it
// in one cycle and takes priority over a simultaneous push or pop.
module line_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [NW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == NW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser: queued line commands in, one pixel per cycle out
// over valid/ready, with abort flush and optional screen clipping.
module line_raster_engine
  import line_pkg::*;
#(
  parameter int XW        = 11,
  parameter int YW        = 10,
  parameter int CW        = 24,
  parameter int CMD_DEPTH = 4,
  parameter int CLIP_EN   = 1,
  parameter int H_MAX     = 800,
  parameter int V_MAX     = 480
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          abort,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x0,
  input  logic [YW-1:0] cmd_y0,
  input  logic [XW-1:0] cmd_x1,
  input  logic [YW-1:0] cmd_y1,
  input  logic [CW-1:0] cmd_color,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [XW-1:0] px_x,
  output logic [YW-1:0] px_y,
  output logic [CW-1:0] px_color,
  output logic          px_last,
  output logic          busy
);

  localparam int EW = err_width(XW, YW);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pt_t;

  typedef struct packed {
    pt_t           p0;
    pt_t           p1;
    logic [CW-1:0] color;
  } cmd_t;

  cmd_t   push_cmd;
  cmd_t   pop_cmd;
  cmd_t   cmd_q;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_push;
  logic   fifo_pop;
  state_t state;
  state_t state_nxt;

  logic                 sx_neg;
  logic                 sy_neg;
  logic signed [EW-1:0] dx;
  logic signed [EW-1:0] dy;
  logic signed [EW-1:0] err;

  logic [XW-1:0]        adx;
  logic [YW-1:0]        ady;
  logic signed [EW-1:0] dx_init;
  logic signed [EW-1:0] dy_init;

  logic signed [EW:0]   e2;
  logic signed [EW:0]   dx_e;
  logic signed [EW:0]   dy_e;
  logic                 step_x;
  logic                 step_y;
  logic signed [EW-1:0] err_nxt;
  logic [XW-1:0]        nx;
  logic [YW-1:0]        ny;
  logic                 adv;
  logic                 at_end;

  function automatic logic on_screen(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (CLIP_EN == 0) || ((32'(x) < H_MAX) && (32'(y) < V_MAX));
  endfunction

  assign push_cmd  = '{p0: '{x: cmd_x0, y: cmd_y0}, p1: '{x: cmd_x1, y: cmd_y1}, color: cmd_color};
  assign fifo_push = cmd_valid && !fifo_full && !reset;
  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  line_cmd_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort),
    .push  (fifo_push),
    .din   (push_cmd),
    .pop   (fifo_pop),
    .dout  (pop_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Setup terms derived from the latched command.
  always_comb begin
    adx     = (cmd_q.p1.x >= cmd_q.p0.x) ? cmd_q.p1.x - cmd_q.p0.x : cmd_q.p0.x - cmd_q.p1.x;
    ady     = (cmd_q.p1.y >= cmd_q.p0.y) ? cmd_q.p1.y - cmd_q.p0.y : cmd_q.p0.y - cmd_q.p1.y;
    dx_init = signed'(EW'(adx));
    dy_init = -signed'(EW'(ady));
  end

  // One Bresenham step from the point currently on px_x/px_y.
  always_comb begin
    e2      = {err, 1'b0};
    dx_e    = {dx[EW-1], dx};
    dy_e    = {dy[EW-1], dy};
    step_x  = (e2 >= dy_e);
    step_y  = (e2 <= dx_e);
    err_nxt = err;
    nx      = px_x;
    ny      = px_y;
    if (step_x) begin
      err_nxt = err_nxt + dy;
      nx      = sx_neg ? px_x - XW'(1) : px_x + XW'(1);
    end
    if (step_y) begin
      err_nxt = err_nxt + dx;
      ny      = sy_neg ? px_y - YW'(1) : px_y + YW'(1);
    end
  end

  // A suppressed (off-screen) point advances without waiting for the sink.
  assign adv    = (state == RUN) && (!px_valid || px_ready);
  assign at_end = (px_x == cmd_q.p1.x) && (px_y == cmd_q.p1.y);

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP:   state_nxt = RUN;
      RUN:     if (adv && at_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      fifo_pop  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state    <= IDLE;
      px_valid <= 1'b0;
      px_last  <= 1'b0;
      px_x     <= '0;
      px_y     <= '0;
      px_color <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (fifo_pop) cmd_q <= pop_cmd;
        end
        SETUP: begin
          dx       <= dx_init;
          dy       <= dy_init;
          err      <= dx_init + dy_init;
          sx_neg   <= (cmd_q.p1.x < cmd_q.p0.x);
          sy_neg   <= (cmd_q.p1.y < cmd_q.p0.y);
          px_x     <= cmd_q.p0.x;
          px_y     <= cmd_q.p0.y;
          px_color <= cmd_q.color;
          px_valid <= on_screen(cmd_q.p0.x, cmd_q.p0.y);
          px_last  <= (cmd_q.p0 == cmd_q.p1) && on_screen(cmd_q.p0.x, cmd_q.p0.y);
        end
        RUN: begin
          if (adv) begin
            if (at_end) begin
              px_valid <= 1'b0;
              px_last  <= 1'b0;
            end else begin
              px_x     <= nx;
              px_y     <= ny;
              err      <= err_nxt;
              px_valid <= on_screen(nx, ny);
              px_last  <= (nx == cmd_q.p1.x) && (ny == cmd_q.p1.y) && on_screen(nx, ny);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
